// File: rtl/dmux_pkg.sv
// Shared constants and helpers for the buffered 8-way 16-bit demux.
// Optional round-robin select is enabled by defining DMUX_RR_EN.
package dmux_pkg;
  localparam int WIDTH = 16;
  localparam int NWAY  = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] idx_t;

  function automatic logic [3:0] popcnt(
    input logic [NWAY-1:0] v
  );
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < NWAY; i++)
      s = s + {3'b000, v[i]};
    return s;
  endfunction
endpackage

// File: rtl/dmux_slot.sv
// One holding slot: data word plus valid flag.
// A load wins over an ack, so a drained slot can be refilled in one cycle.
module dmux_slot
  import dmux_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic             ack,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             vld
);
  logic [WIDTH-1:0] data_d, data_q;
  logic             vld_d, vld_q;

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (load) begin
      data_d = din;
      vld_d  = 1'b1;
    end else if (ack) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign dout = data_q;
  assign vld  = vld_q;
endmodule

// File: rtl/dmux_8way_16_buf.sv
// Buffered 1-to-8 demux of 16-bit words with per-slot acknowledge.
// Define DMUX_RR_EN to add the RR input and round-robin target pointer.
module dmux_8way_16_buf
  import dmux_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
`ifdef DMUX_RR_EN
  input  logic             RR,
`endif
  input  logic [WIDTH-1:0] I,
  input  logic             S1,
  input  logic             S2,
  input  logic             S3,
  input  logic             IV,
  output logic             IR,
  output logic [WIDTH-1:0] O1,
  output logic [WIDTH-1:0] O2,
  output logic [WIDTH-1:0] O3,
  output logic [WIDTH-1:0] O4,
  output logic [WIDTH-1:0] O5,
  output logic [WIDTH-1:0] O6,
  output logic [WIDTH-1:0] O7,
  output logic [WIDTH-1:0] O8,
  output logic [NWAY-1:0]  V,
  input  logic [NWAY-1:0]  A,
  output logic [3:0]       CNT,
  output logic             FULL,
  output logic             EMPTY
);
  idx_t             tgt;
  logic             xfer;
  logic [NWAY-1:0]  load;
  logic [NWAY-1:0]  vld;
  logic [WIDTH-1:0] data [NWAY];
  logic [3:0]       cnt_d, cnt_q;

`ifdef DMUX_RR_EN
  idx_t ptr_d, ptr_q;

  assign tgt = RR ? ptr_q : {S3, S2, S1};

  always_comb begin
    ptr_d = ptr_q;
    if (xfer && RR)
      ptr_d = ptr_q + 3'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  assign tgt = {S3, S2, S1};
`endif

  assign IR   = ~vld[tgt] | A[tgt];
  assign xfer = IV & IR;

  always_comb begin
    load      = '0;
    load[tgt] = xfer;
  end

  for (genvar k = 0; k < NWAY; k++) begin : g_slot
    dmux_slot u_slot (
      .CLK  (CLK),
      .RST  (RST),
      .load (load[k]),
      .ack  (A[k]),
      .din  (I),
      .dout (data[k]),
      .vld  (vld[k])
    );
  end

  // A replaced slot stays occupied, so its ack does not decrement.
  always_comb begin
    cnt_d = cnt_q
          + {3'b000, xfer & ~vld[tgt]}
          - popcnt(A & vld & ~load);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign O1    = data[0];
  assign O2    = data[1];
  assign O3    = data[2];
  assign O4    = data[3];
  assign O5    = data[4];
  assign O6    = data[5];
  assign O7    = data[6];
  assign O8    = data[7];
  assign V     = vld;
  assign CNT   = cnt_q;
  assign FULL  = (cnt_q == 4'd8);
  assign EMPTY = (cnt_q == 4'd0);
endmodule
